uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART serial-to-parallel datapath. It synchronises the rx line, detects the start bit, and times each bit to its centre using an oversampling enable. It drives the one-cycle shift strobe and the sampled bit into the SIPO shifter, checks the stop bit (and parity when enabled), and presents the captured word on a valid/ready handshake with framing and overrun flags.

Parameters:
DATA_WIDTH, `DATA_WIDTH (8), data bits per frame; must match the SIPO width.
OVERSAMPLE, 16, sample_tick pulses per bit period; even, ≥4.

Ports:
rx_clk  input  1  receive clock; all logic on posedge.
rx_rst_n  input  1  synchronous, active-low reset, sampled on posedge rx_clk.
sample_tick  input  1  one-rx_clk-wide enable at OVERSAMPLE × baud.
rx_in  input  1  asynchronous serial line; idles high.
shift  output  1  one-cycle strobe to SIPO, exactly one per data bit.
serial_bit  output  1  sampled bit value, valid while shift=1.
parallel_in  input  DATA_WIDTH  word from SIPO parallel_out.
rx_data  output  DATA_WIDTH  captured word.
rx_valid  output  1  rx_data holds an unconsumed word.
rx_ready  input  1  consumer accepts rx_data when rx_valid&rx_ready.
framing_err  output  1  one-cycle pulse: stop bit sampled low.
overrun_err  output  1  one-cycle pulse: frame completed while the previous word was unconsumed.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rx_rst_n=0 at a posedge): state=IDLE; tick and bit counters=0; synchroniser flops=1; shift, serial_bit, rx_valid, framing_err, overrun_err, busy=0; rx_data=0. Reset mid-frame aborts the frame with no further shift strobes.
- rx_in passes through a 2-flop synchroniser (rx_s). Line-to-decision latency is 2 rx_clk cycles.
- Tick counter advances only on sample_tick; bit counter has width $clog2(DATA_WIDTH+1).
- IDLE: rx_s=0 → START, tick counter cleared.
- START: on the sample_tick where count reaches OVERSAMPLE/2-1, sample rx_s. If 0 → DATA with counters cleared. If 1 → false start, return to IDLE with no strobe and no flags.
- DATA: on the OVERSAMPLE-th tick (bit centre), assert shift=1 for one rx_clk with serial_bit=rx_s, and increment the bit counter. Data is LSB first. After DATA_WIDTH strobes → PARITY if enabled, else STOP.
- STOP: sample at bit centre.
  - If 1: capture rx_data ← parallel_in in that cycle and set rx_valid.
  - If 0: pulse framing_err; no capture, rx_valid unchanged.
  - Next state is IDLE. After a framing error, move to IDLE only once rx_s=1, so a break does not retrigger START.
- Handshake:
  - rx_valid clears on the cycle after rx_valid&rx_ready.
  - Completion while rx_valid=1 and rx_ready=0: pulse overrun_err, keep the old rx_data, discard the new word.
  - Completion in the same cycle as rx_valid&rx_ready: load the new word, keep rx_valid=1, no overrun.
- A sample_tick while shift is asserted is handled normally; there is at most one strobe per bit.
- The SIPO sees exactly DATA_WIDTH strobes per frame that reaches STOP, and none for a false start.

Optional Feature:
UART_RX_PARITY_EN.
- Defined: PARITY state follows DATA. The bit is sampled at its centre with no shift strobe. Even parity is required: XOR of the data bits and the parity bit = 0. Adds output parity_err (1 bit), a one-cycle pulse at the STOP sample. On mismatch, rx_data is not captured; rx_valid is unchanged and overrun is not evaluated.
- Undefined: no PARITY state, no parity_err port; frame is start + DATA_WIDTH data bits + stop.

Decomposition:
- uart_params.vh holds `DATA_WIDTH, `OVERSAMPLE and the state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit.
- One sub-module, rx_sync: 2-flop synchroniser with reset value 1.

Test Plan:
1. OVERSAMPLE=16, tick every cycle, frame 0xA5 with valid stop → 8 shift pulses carrying serial_bit 1,0,1,0,0,1,0,1; rx_data=0xA5, rx_valid=1, no flags.
2. rx_in low for 5 ticks, then high → return to IDLE; zero shift pulses, busy drops, rx_valid stays 0.
3. Frame 0x3C with stop=0 → framing_err single pulse, rx_valid stays 0; line held low 40 ticks → no new START until rx_in=1.
4. Two frames 0x11, 0x22 with rx_ready=0 → rx_data=0x11, overrun_err pulses once. Repeat with rx_ready=1 on the completion cycle → rx_data=0x22, rx_valid=1, no overrun.
5. rx_rst_n=0 for 1 cycle after the 3rd data bit → all outputs at reset values, no further shifts; next full frame 0x7E is received correctly.
6. (UART_RX_PARITY_EN) frame 0x07 with parity bit 1 → accepted; same frame with parity bit 0 → parity_err pulse, rx_valid stays 0.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_pkg
// Shared definitions for the UART receive controller: default frame
// geometry and the receive FSM state encoding (3-bit, IDLE=0 .. STOP=4).
// ---------------------------------------------------------------------------
package uart_rx_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;   // data bits per frame
    localparam int DEF_OVERSAMPLE = 16;  // sample_tick pulses per bit period

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_sync.sv
// ---------------------------------------------------------------------------
// rx_sync
// Two-flop synchroniser for the asynchronous serial line. Resets to 1 (line
// idle level) so that leaving reset never looks like a start bit.
// Ports:
//   i_clk    receive clock
//   i_rst_n  synchronous active-low reset
//   i_d      asynchronous input
//   o_q      synchronised output (2 cycles of latency)
// ---------------------------------------------------------------------------
module rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side sequencer for the UART serial-to-parallel datapath. Detects
// the start bit, times every bit to its centre from sample_tick, strobes the
// external SIPO once per data bit, checks the stop bit (and even parity when
// built with UART_RX_PARITY_EN) and holds the received word on a
// valid/ready handshake with framing / overrun pulses.
//
// Build option: `define UART_RX_PARITY_EN adds a parity bit between the data
// and stop bits plus the parity_err output.
//
// Ports:
//   rx_clk, rx_rst_n     clock, synchronous active-low reset
//   sample_tick          enable at OVERSAMPLE x baud
//   rx_in                asynchronous serial line (idle high)
//   shift, serial_bit    one-cycle strobe + bit value to the SIPO
//   parallel_in          SIPO parallel output
//   rx_data, rx_valid    captured word and its valid flag
//   rx_ready             consumer accept
//   framing_err          pulse: stop bit sampled low
//   overrun_err          pulse: word completed while previous unconsumed
//   parity_err           pulse: parity mismatch (UART_RX_PARITY_EN only)
//   busy                 high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst_n,
    input  logic                  sample_tick,
    input  logic                  rx_in,
    output logic                  shift,
    output logic                  serial_bit,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  framing_err,
    output logic                  overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_t             r_state, w_next;
    logic [TW-1:0]         r_tick_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_shift, r_serial_bit;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid, r_framing, r_overrun;
    logic                  r_brk;     // stop bit was low; waiting for line high

    logic w_rx_s;
    logic w_at_half, w_at_full;
    logic w_tick_clr, w_tick_inc;
    logic w_shift, w_stop_sample, w_brk_next;
    logic w_par_ok, w_capture;

`ifdef UART_RX_PARITY_EN
    logic r_par;                      // running XOR of data + parity bits
    logic r_parity_err;
    logic w_par_sample;
`endif

    rx_sync u_sync (
        .i_clk   (rx_clk),
        .i_rst_n (rx_rst_n),
        .i_d     (rx_in),
        .o_q     (w_rx_s)
    );

    assign w_at_half = sample_tick && (r_tick_cnt == HALF_M1);
    assign w_at_full = sample_tick && (r_tick_cnt == FULL_M1);

    // Next-state / strobe decode
    always_comb begin
        w_next        = r_state;
        w_tick_clr    = 1'b0;
        w_tick_inc    = 1'b0;
        w_shift       = 1'b0;
        w_stop_sample = 1'b0;
        w_brk_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tick_clr = 1'b1;
                if (!w_rx_s) w_next = ST_START;
            end
            ST_START: begin
                if (w_at_half) begin
                    w_tick_clr = 1'b1;
                    // Line back high at mid start bit: glitch, not a frame
                    w_next     = w_rx_s ? ST_IDLE : ST_DATA;
                end else if (sample_tick) begin
                    w_tick_inc = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_at_full) begin
                    w_tick_clr = 1'b1;
                    w_shift    = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_next = ST_PARITY;
`else
                        w_next = ST_STOP;
`endif
                    end
                end else if (sample_tick) begin
                    w_tick_inc = 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_at_full) begin
                    w_tick_clr   = 1'b1;
                    w_par_sample = 1'b1;
                    w_next       = ST_STOP;
                end else if (sample_tick) begin
                    w_tick_inc = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (r_brk) begin
                    // Hold here through a break so a low line is not a new start
                    if (w_rx_s) w_next = ST_IDLE;
                    else        w_brk_next = 1'b1;
                end else if (w_at_full) begin
                    w_tick_clr    = 1'b1;
                    w_stop_sample = 1'b1;
                    if (w_rx_s) w_next = ST_IDLE;
                    else        w_brk_next = 1'b1;
                end else if (sample_tick) begin
                    w_tick_inc = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_ok = !r_par;
`else
    assign w_par_ok = 1'b1;
`endif
    assign w_capture = w_stop_sample && w_rx_s && w_par_ok;

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            r_state      <= ST_IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= 1'b0;
            r_serial_bit <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_framing    <= 1'b0;
            r_overrun    <= 1'b0;
            r_brk        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_brk   <= w_brk_next;

            if (w_tick_clr)      r_tick_cnt <= '0;
            else if (w_tick_inc) r_tick_cnt <= r_tick_cnt + TW'(1);

            if (r_state == ST_IDLE) r_bit_cnt <= '0;
            else if (w_shift)       r_bit_cnt <= r_bit_cnt + BW'(1);

            r_shift <= w_shift;
            if (w_shift) r_serial_bit <= w_rx_s;

            r_framing <= w_stop_sample && !w_rx_s;
            r_overrun <= 1'b0;

            // A same-cycle accept frees the buffer, so the new word loads
            if (w_capture) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= parallel_in;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == ST_IDLE)           r_par <= 1'b0;
            else if (w_shift || w_par_sample) r_par <= r_par ^ w_rx_s;
            r_parity_err <= w_stop_sample && r_par;
        end
    end
    assign parity_err = r_parity_err;
`endif

    assign shift       = r_shift;
    assign serial_bit  = r_serial_bit;
    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign framing_err = r_framing;
    assign overrun_err = r_overrun;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl with OVERSAMPLE=16 and sample_tick held
// high. A behavioural SIPO feeds parallel_in from shift/serial_bit; monitors
// count strobes and error pulses. Define UART_RX_PARITY_EN to also cover
// the parity frame format.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          rx_clk = 1'b0;
    logic          rx_rst_n = 1'b0;
    logic          sample_tick = 1'b1;
    logic          rx_in = 1'b1;
    logic          rx_ready = 1'b0;
    logic          shift, serial_bit, rx_valid, framing_err, overrun_err, busy;
    logic [DW-1:0] parallel_in, rx_data;
    logic [DW-1:0] sipo = '0;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    int checks = 0;
    int failures = 0;
    int n_shift, n_fe, n_ov, n_pe;
    logic [31:0] shbits;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .rx_clk      (rx_clk),
        .rx_rst_n    (rx_rst_n),
        .sample_tick (sample_tick),
        .rx_in       (rx_in),
        .shift       (shift),
        .serial_bit  (serial_bit),
        .parallel_in (parallel_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy)
    );

    always #5 rx_clk = ~rx_clk;

    // Environment SIPO: LSB arrives first, so shift right from the top
    always @(posedge rx_clk)
        if (shift) sipo <= {serial_bit, sipo[DW-1:1]};
    assign parallel_in = sipo;

    always @(negedge rx_clk) begin
        if (shift) begin
            if (n_shift < 32) shbits[n_shift] = serial_bit;
            n_shift++;
        end
        if (framing_err) n_fe++;
        if (overrun_err) n_ov++;
`ifdef UART_RX_PARITY_EN
        if (parity_err)  n_pe++;
`endif
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge rx_clk);
            #1;
        end
    endtask

    task automatic clr_counts();
        n_shift = 0; n_fe = 0; n_ov = 0; n_pe = 0; shbits = '0;
    endtask

    // Drives one frame, one bit per OS cycles. ready_pulse raises rx_ready
    // for exactly the cycle whose edge samples the stop bit. abort_at>0
    // stops driving after that many cycles.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_b,
                              input logic par_b, input logic ready_pulse,
                              input int abort_at);
        logic [DW+2:0] bits;
        int ncyc;
        bits = '0;
        for (int i = 0; i < DW; i++) bits[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
        bits[DW+1] = par_b;
        bits[DW+2] = stop_b;
`else
        bits[DW+1] = stop_b;
        bits[DW+2] = par_b;   // spare slot, never transmitted in this format
`endif
        ncyc = (abort_at > 0) ? abort_at : NB * OS;
        for (int c = 0; c < ncyc; c++) begin
            rx_in    = bits[c / OS];
            rx_ready = ready_pulse && (c == (NB - 1) * OS + 10);
            step(1);
        end
        rx_in    = 1'b1;
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rx_rst_n = 1'b0;
        step(3);
        checks++; if (shift !== 1'b0)      begin failures++; $display("FAIL reset_shift got=%b exp=0", shift); end
        checks++; if (serial_bit !== 1'b0) begin failures++; $display("FAIL reset_serial_bit got=%b exp=0", serial_bit); end
        checks++; if (rx_valid !== 1'b0)   begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'h00)   begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (framing_err !== 1'b0) begin failures++; $display("FAIL reset_framing got=%b exp=0", framing_err); end
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun_err); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rx_rst_n = 1'b1;
        step(20);
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL post_reset_idle got=%b exp=0", busy); end
    endtask

    task automatic test_frame();
        clr_counts();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
        step(4);
        checks++; if (n_shift != 8)          begin failures++; $display("FAIL a5_shift_count got=%0d exp=8", n_shift); end
        checks++; if (shbits[7:0] !== 8'hA5) begin failures++; $display("FAIL a5_serial_bits got=%h exp=a5", shbits[7:0]); end
        checks++; if (rx_data !== 8'hA5)     begin failures++; $display("FAIL a5_rx_data got=%h exp=a5", rx_data); end
        checks++; if (rx_valid !== 1'b1)     begin failures++; $display("FAIL a5_rx_valid got=%b exp=1", rx_valid); end
        checks++; if (n_fe != 0 || n_ov != 0) begin failures++; $display("FAIL a5_flags got fe=%0d ov=%0d exp 0/0", n_fe, n_ov); end
        checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL a5_busy got=%b exp=0", busy); end
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0)     begin failures++; $display("FAIL a5_consume got=%b exp=0", rx_valid); end
    endtask

    task automatic test_false_start();
        clr_counts();
        rx_in = 1'b0;
        step(5);
        checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL fs_busy_high got=%b exp=1", busy); end
        rx_in = 1'b1;
        step(30);
        checks++; if (n_shift != 0)      begin failures++; $display("FAIL fs_shift_count got=%0d exp=0", n_shift); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL fs_busy_low got=%b exp=0", busy); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL fs_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (n_fe != 0)         begin failures++; $display("FAIL fs_framing got=%0d exp=0", n_fe); end
    endtask

    task automatic test_framing();
        clr_counts();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
        rx_in = 1'b0;
        step(40);
        checks++; if (n_fe != 1)             begin failures++; $display("FAIL fe_pulse_count got=%0d exp=1", n_fe); end
        checks++; if (shbits[7:0] !== 8'h3C) begin failures++; $display("FAIL fe_serial_bits got=%h exp=3c", shbits[7:0]); end
        checks++; if (rx_valid !== 1'b0)     begin failures++; $display("FAIL fe_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'hA5)     begin failures++; $display("FAIL fe_rx_data_kept got=%h exp=a5", rx_data); end
        checks++; if (busy !== 1'b1)         begin failures++; $display("FAIL fe_break_hold got=%b exp=1", busy); end
        rx_in = 1'b1;
        step(40);
        checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL fe_release got=%b exp=0", busy); end
        checks++; if (n_shift != 8 || n_fe != 1) begin failures++; $display("FAIL fe_no_restart got shifts=%0d fe=%0d exp 8/1", n_shift, n_fe); end
    endtask

    task automatic test_overrun();
        clr_counts();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 0);
        step(4);
        checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL ov_rx_data got=%h exp=11", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ov_rx_valid got=%b exp=1", rx_valid); end
        checks++; if (n_ov != 1)         begin failures++; $display("FAIL ov_pulse_count got=%0d exp=1", n_ov); end
        clr_counts();
        send_frame(8'h22, 1'b1, 1'b0, 1'b1, 0);
        step(2);
        checks++; if (rx_data !== 8'h22) begin failures++; $display("FAIL b2b_rx_data got=%h exp=22", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_rx_valid got=%b exp=1", rx_valid); end
        checks++; if (n_ov != 0)         begin failures++; $display("FAIL b2b_overrun got=%0d exp=0", n_ov); end
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        clr_counts();
        // Third data strobe lands at cycle 59 of the frame
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 62);
        rx_rst_n = 1'b0;
        step(1);
        checks++; if (n_shift != 3)      begin failures++; $display("FAIL mr_pre_shifts got=%0d exp=3", n_shift); end
        checks++; if (shift !== 1'b0 || serial_bit !== 1'b0) begin failures++; $display("FAIL mr_shift_out got=%b%b exp=00", shift, serial_bit); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL mr_busy got=%b exp=0", busy); end
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin failures++; $display("FAIL mr_rx got v=%b d=%h exp 0/00", rx_valid, rx_data); end
        rx_rst_n = 1'b1;
        step(40);
        checks++; if (n_shift != 3)      begin failures++; $display("FAIL mr_no_more_shifts got=%0d exp=3", n_shift); end
        clr_counts();
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 0);
        step(2);
        checks++; if (rx_data !== 8'h7E || rx_valid !== 1'b1) begin failures++; $display("FAIL mr_next_frame got d=%h v=%b exp 7e/1", rx_data, rx_valid); end
        checks++; if (n_shift != 8)      begin failures++; $display("FAIL mr_next_shifts got=%0d exp=8", n_shift); end
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clr_counts();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0);
        step(2);
        checks++; if (rx_data !== 8'h07 || rx_valid !== 1'b1) begin failures++; $display("FAIL par_ok_rx got d=%h v=%b exp 07/1", rx_data, rx_valid); end
        checks++; if (n_pe != 0 || n_shift != 8) begin failures++; $display("FAIL par_ok_flags got pe=%0d sh=%0d exp 0/8", n_pe, n_shift); end
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        clr_counts();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 0);
        step(2);
        checks++; if (n_pe != 1)         begin failures++; $display("FAIL par_bad_pulse got=%0d exp=1", n_pe); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL par_bad_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (n_ov != 0 || n_fe != 0) begin failures++; $display("FAIL par_bad_flags got ov=%0d fe=%0d exp 0/0", n_ov, n_fe); end
    endtask
`endif

    initial begin
        clr_counts();
        test_reset();
        test_frame();
        test_false_start();
        test_framing();
        test_overrun();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
